demux_stream: RTL and testbench
===============================

# demux_stream

Parametrised, registered 1-to-NCH stream demultiplexer with per-channel valid/ready handshake, packet-level select locking and a unicast/broadcast mode. It is the sequential successor to the combinational 1-to-8 demux in the lab set. It sits between a single producer stream and NCH consumer lanes, and absorbs consumer back-pressure through a one-beat output register.

## Interface
- WIDTH, 8, data bits per beat
- NCH, 8, number of output channels (2..16)
- SELW, $clog2(NCH), select width (derived; do not override)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  producer beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  WIDTH  beat payload
- in_sel  in  SELW  destination channel; sampled on first beat of packet only
- in_mode  in  1  0 = unicast, 1 = broadcast; sampled on first beat of packet only
- in_last  in  1  final beat of packet
- out_valid  out  NCH  per-channel valid
- out_ready  in  NCH  per-channel ready
- out_data  out  WIDTH  shared payload bus, valid where out_valid bit set
- out_last  out  1  registered copy of in_last for the held beat
- drop_cnt  out  8  saturating count of beats dropped for out-of-range select

## Operation
- Beat accepted when in_valid && in_ready.
- Packet FSM, states IDLE and LOCK:
  - IDLE: on accepted beat, latch dest mask; if !in_last go to LOCK.
  - LOCK: dest mask frozen, in_sel/in_mode ignored; accepted beat with in_last returns to IDLE.
- Dest mask: unicast gives one-hot(in_sel); broadcast gives all NCH bits set.
- Out-of-range select: unicast with in_sel >= NCH (only possible when NCH is not a power of 2) makes the beat accepted and discarded, drop_cnt += 1 saturating at 255. FSM still tracks in_last, so the rest of that packet is also dropped and counted.
- Output register: full flag, data, last, pending mask. out_valid = pending when full, else 0.
- Each cycle, pending clears bits where out_valid & out_ready. The beat completes when pending becomes 0.
- Broadcast: a channel that has accepted is not re-presented. The beat completes only when every channel has accepted, in any order and over any number of cycles.
- in_ready = !rst && (!full || (pending & ~out_ready) == 0). This gives back-to-back throughput when all pending consumers are ready.
- Reset: out_valid = 0, out_data = 0, out_last = 0, drop_cnt = 0, FSM = IDLE, in_ready = 0 while rst high. Reset mid-packet discards the held beat and the lock.

## Timing
- Latency: 1 cycle from acceptance to out_valid.
- Throughput: 1 beat/cycle unicast with out_ready held high. Broadcast is 1 beat/cycle only if all out_ready bits are high.
- out_data and out_last are stable while any out_valid bit is high. out_valid bits only fall after a handshake.
- Simultaneous completion of the held beat and acceptance of a new beat: the register loads the new beat with no bubble.
- Dropped beat: never occupies the register and never asserts out_valid. in_ready is unaffected by the drop.

## Structure
- Shared package demux_pkg: mode constants MODE_UNICAST = 1'b0 and MODE_BROADCAST = 1'b1, FSM state typedef {IDLE, LOCK}, DROP_CNT_W = 8.
- No sub-module needed. The one-hot decode is a function in the package, reused by the combinational demux.

## Test plan
- Unicast sweep: NCH=8, WIDTH=8, single-beat packets, in_sel = 0..7, data = 8'hA0+sel, all ready → out_valid = 1<<sel one cycle later with out_data = 8'hA0+sel, 8 beats in 9 cycles.
- Select lock: 3-beat packet, first beat in_sel=2, later beats in_sel=5 → all 3 beats on channel 2 only, out_last on beat 3, next packet's in_sel honoured.
- Broadcast stagger: in_mode=1, data 8'h5A, out_ready bits raised one per cycle from ch0 to ch7 → out_valid drops bit by bit, in_ready stays low until cycle 8, exactly one beat per channel.
- Back-pressure: unicast ch3, out_ready[3]=0 for 4 cycles → out_data held 8'h33, in_ready=0, no beat lost or duplicated after release.
- Drop: NCH=6, in_sel=7, 2-beat packet → no out_valid, drop_cnt = 2. With 300 such beats drop_cnt stays at 255.
- Reset mid-packet: assert rst in LOCK with a beat held → out_valid=0 and drop_cnt=0 immediately (asynchronous). After release, a new first beat with in_sel=1 routes to channel 1.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: shared mode constants, packet FSM states and one-hot decode for the stream demux.
package demux_pkg;
    localparam logic MODE_UNICAST   = 1'b0;
    localparam logic MODE_BROADCAST = 1'b1;
    localparam int   DROP_CNT_W     = 8;

    typedef enum logic {IDLE, LOCK} state_e;

    function automatic logic [15:0] onehot(input logic [3:0] sel);
        return 16'(1) << sel;
    endfunction
endpackage

// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-NCH stream demux with packet select locking and unicast/broadcast.
module demux_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 8,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SELW-1:0]       in_sel,
    input  logic                  in_mode,
    input  logic                  in_last,
    output logic [NCH-1:0]        out_valid,
    input  logic [NCH-1:0]        out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic [DROP_CNT_W-1:0] drop_cnt
);
    state_e                state_q, state_d;
    logic [NCH-1:0]        mask_q, mask_d, pend_q, pend_d, cur_mask;
    logic [WIDTH-1:0]      data_q, data_d;
    logic                  last_q, last_d, acc, load;
    logic [DROP_CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]           oh;

    assign oh       = onehot(4'(in_sel));
    // An all-zero destination (unicast to a missing channel) marks the whole packet as dropped.
    assign cur_mask = (state_q == LOCK) ? mask_q : (in_mode == MODE_BROADCAST) ? '1 : oh[NCH-1:0];
    assign in_ready = !rst && ((pend_q & ~out_ready) == '0);
    assign acc      = in_valid && in_ready;
    assign load     = acc && (cur_mask != '0);

    assign out_valid = pend_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign drop_cnt  = cnt_q;

    always_comb begin
        state_d = acc ? (in_last ? IDLE : LOCK) : state_q;
        mask_d  = (acc && state_q == IDLE) ? cur_mask : mask_q;
        pend_d  = load ? cur_mask : (pend_q & ~out_ready);
        data_d  = load ? in_data : data_q;
        last_d  = load ? in_last : last_q;
        cnt_d   = (acc && !load && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            pend_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: directed table/sequence checks on NCH=8 and randomized model checks on NCH=6.
module tb_demux_stream;
    logic clk = 1'b0, rst = 1'b1;
    logic v8 = 0, m8 = 0, l8 = 0, inr8, ol8;
    logic [2:0] s8 = 0;
    logic [7:0] d8 = 0, r8 = 0, ov8, od8, dc8;
    logic v6 = 0, m6 = 0, l6 = 0, inr6, ol6;
    logic [2:0] s6 = 0;
    logic [7:0] d6 = 0, od6, dc6;
    logic [5:0] r6 = 0, ov6;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    demux_stream #(.WIDTH(8), .NCH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(inr8), .in_data(d8), .in_sel(s8),
        .in_mode(m8), .in_last(l8), .out_valid(ov8), .out_ready(r8), .out_data(od8),
        .out_last(ol8), .drop_cnt(dc8));

    demux_stream #(.WIDTH(8), .NCH(6)) u6 (
        .clk(clk), .rst(rst), .in_valid(v6), .in_ready(inr6), .in_data(d6), .in_sel(s6),
        .in_mode(m6), .in_last(l6), .out_valid(ov6), .out_ready(r6), .out_data(od6),
        .out_last(ol6), .drop_cnt(dc6));

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       v;
        logic [2:0] sel;
        logic [7:0] d;
        logic [7:0] eov;
        logic [7:0] eod;
    } vec_t;

    vec_t tab[9];
    logic [2:0] ls[4];
    logic [7:0] ld[4];
    logic       ll[4];
    logic [5:0] exp_pend, lmask, dest;
    logic [7:0] ed, exp_drop;
    logic       el, locked, inr_e;

    initial begin
        for (int i = 0; i < 9; i++) begin
            tab[i].v   = (i < 8);
            tab[i].sel = 3'(i);
            tab[i].d   = 8'(8'hA0 + i);
            tab[i].eov = (i == 0) ? 8'h00 : 8'(1 << (i - 1));
            tab[i].eod = 8'(8'hA0 + i - 1);
        end
        ls = '{3'd2, 3'd5, 3'd5, 3'd5};
        ld = '{8'h11, 8'h12, 8'h13, 8'h14};
        ll = '{1'b0, 1'b0, 1'b1, 1'b1};

        #3;
        chk("rst_inr", inr8, 0);
        chk("rst_ov", ov8, 0);
        chk("rst_od", od8, 0);
        chk("rst_ol", ol8, 0);
        chk("rst_dc", dc8, 0);
        cyc();
        rst = 0;

        m8 = 0; l8 = 1; r8 = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) cyc();
            v8 = tab[i].v; s8 = tab[i].sel; d8 = tab[i].d;
            @(negedge clk);
            chk("sweep_ov", ov8, tab[i].eov);
            if (tab[i].eov != 0) chk("sweep_od", od8, tab[i].eod);
            chk("sweep_inr", inr8, 1);
        end

        for (int i = 0; i < 5; i++) begin
            cyc();
            v8 = (i < 4);
            if (i < 4) begin s8 = ls[i]; d8 = ld[i]; l8 = ll[i]; end
            @(negedge clk);
            if (i > 0) begin
                chk("lock_ov", ov8, (i <= 3) ? 8'h04 : 8'h20);
                chk("lock_od", od8, ld[i-1]);
                chk("lock_ol", ol8, ll[i-1]);
            end
        end

        cyc();
        v8 = 1; m8 = 1; d8 = 8'h5A; l8 = 1; s8 = 0; r8 = 0;
        @(negedge clk);
        chk("bc_inr0", inr8, 1);
        for (int k = 0; k < 8; k++) begin
            cyc();
            v8 = 0; r8 = 8'((2 << k) - 1);
            @(negedge clk);
            chk("bc_ov", ov8, 8'(8'hFF << k));
            chk("bc_od", od8, 8'h5A);
            chk("bc_inr", inr8, (k == 7));
        end
        cyc();
        r8 = 8'hFF;
        @(negedge clk);
        chk("bc_done", ov8, 0);

        cyc();
        v8 = 1; m8 = 0; s8 = 3; d8 = 8'h33; l8 = 1; r8 = 8'hF7;
        @(negedge clk);
        chk("bp_inr0", inr8, 1);
        for (int k = 0; k < 4; k++) begin
            cyc();
            d8 = 8'h44;
            @(negedge clk);
            chk("bp_ov", ov8, 8'h08);
            chk("bp_od", od8, 8'h33);
            chk("bp_inr", inr8, 0);
        end
        cyc();
        r8 = 8'hFF;
        @(negedge clk);
        chk("bp_rel_ov", ov8, 8'h08);
        chk("bp_rel_od", od8, 8'h33);
        chk("bp_rel_inr", inr8, 1);
        cyc();
        v8 = 0;
        @(negedge clk);
        chk("bp_next_ov", ov8, 8'h08);
        chk("bp_next_od", od8, 8'h44);
        cyc();
        @(negedge clk);
        chk("bp_idle", ov8, 0);

        cyc();
        v6 = 1; s6 = 7; m6 = 0; l6 = 0; d6 = 8'h01; r6 = '1;
        @(negedge clk);
        chk("drop_inr", inr6, 1);
        cyc();
        l6 = 1;
        @(negedge clk);
        chk("drop_ov1", ov6, 0);
        cyc();
        v6 = 0;
        @(negedge clk);
        chk("drop_ov2", ov6, 0);
        chk("drop_cnt2", dc6, 2);
        for (int i = 0; i < 300; i++) begin
            cyc();
            v6 = 1; l6 = 1;
            @(negedge clk);
            if (i == 100) chk("drop_cnt102", dc6, 102);
        end
        cyc();
        v6 = 0;
        @(negedge clk);
        chk("drop_sat", dc6, 255);

        cyc();
        v8 = 1; m8 = 0; s8 = 4; d8 = 8'h66; l8 = 0; r8 = 0;
        cyc();
        v8 = 0;
        @(negedge clk);
        chk("rstm_held", ov8, 8'h10);
        rst = 1;
        #1;
        chk("rstm_ov", ov8, 0);
        chk("rstm_od", od8, 0);
        chk("rstm_inr", inr8, 0);
        chk("rstm_dc6", dc6, 0);
        cyc();
        rst = 0;
        v8 = 1; s8 = 1; d8 = 8'h77; l8 = 1; r8 = 8'hFF;
        @(negedge clk);
        chk("rstm_inr1", inr8, 1);
        cyc();
        v8 = 0;
        @(negedge clk);
        chk("rstm_route", ov8, 8'h02);
        chk("rstm_od1", od8, 8'h77);

        exp_pend = 0; exp_drop = 0; locked = 0; lmask = 0; ed = 0; el = 0;
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk);
            inr_e = ((exp_pend & ~r6) == 0);
            exp_pend = exp_pend & ~r6;
            if (v6 && inr_e) begin
                dest = locked ? lmask : m6 ? 6'h3F : (s6 < 6) ? 6'(1 << s6) : 6'h00;
                if (!locked) lmask = dest;
                locked = !l6;
                if (dest == 0) begin
                    if (exp_drop != 8'hFF) exp_drop = exp_drop + 1;
                end else begin
                    exp_pend = dest; ed = d6; el = l6;
                end
            end
            #1;
            v6 = ($urandom_range(0, 3) != 0);
            s6 = 3'($urandom_range(0, 7));
            m6 = ($urandom_range(0, 4) == 0);
            l6 = ($urandom_range(0, 2) == 0);
            d6 = 8'($urandom);
            r6 = 6'($urandom) | 6'($urandom);
            @(negedge clk);
            chk("rnd_ov", ov6, exp_pend);
            if (exp_pend != 0) begin
                chk("rnd_od", od6, ed);
                chk("rnd_ol", ol6, el);
            end
            chk("rnd_inr", inr6, ((exp_pend & ~r6) == 0));
            chk("rnd_dc", dc6, exp_drop);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
